// File: rtl/adc_reader_pkg.sv
// Shared types and constants for the periodic SPI ADC read-out master.
package adc_reader_pkg;

    localparam int unsigned FRAME_BITS = 16;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        LOW,
        HIGH,
        HOLD,
        DONE
    } state_e;

    // Frame length in clk cycles, from the first SETUP cycle to DONE.
    function automatic int unsigned frame_len(input int unsigned clk_div);
        return 34 * clk_div;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous bit.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/adc_reader.sv
// Periodic SPI master reading a 16-bit CPOL=1 frame from a serial ADC on each timer tick.
module adc_reader
    import adc_reader_pkg::*;
#(
    parameter int unsigned CLK_DIV       = 4,
    parameter int unsigned SAMPLE_PERIOD = 1200,
    parameter int unsigned ADC_BITS      = 12
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic        enable_i,
    input  logic        miso_i,
    output logic        cs_no,
    output logic        sclk_o,
    output logic [15:0] data_o,
    output logic        data_rdy_o,
    output logic        frame_err_o
);

    localparam int unsigned TW = $clog2(SAMPLE_PERIOD);
    localparam int unsigned PW = $clog2(CLK_DIV);
    localparam logic [FRAME_BITS-1:0] DATA_MASK = FRAME_BITS'((33'd1 << ADC_BITS) - 33'd1);

    state_e                state_q, state_d;
    logic [TW-1:0]         timer_q;
    logic [PW-1:0]         phase_q;
    logic [4:0]            bitcnt_q;
    logic [FRAME_BITS-1:0] shreg_q;
    logic [15:0]           data_q;
    logic                  cs_q, sclk_q, rdy_q, err_q;
    logic                  cs_d, sclk_d, rdy_d, err_d;
    logic                  miso_s, tick, phase_last, sample;

    sync_2ff u_miso_sync (
        .clk_i  (clk_i),
        .rst_ni (reset_ni),
        .d_i    (miso_i),
        .q_o    (miso_s)
    );

    assign tick       = (timer_q == TW'(SAMPLE_PERIOD - 1));
    assign phase_last = (phase_q == PW'(CLK_DIV - 1));
    assign sample     = (state_q == HIGH) && phase_last;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            timer_q <= '0;
        end else if (tick) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_q + TW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            phase_q  <= '0;
            bitcnt_q <= '0;
            shreg_q  <= '0;
        end else begin
            if (state_q == IDLE || state_q == DONE || phase_last) begin
                phase_q <= '0;
            end else begin
                phase_q <= phase_q + PW'(1);
            end
            if (state_q == IDLE) begin
                bitcnt_q <= '0;
            end else if (sample) begin
                bitcnt_q <= bitcnt_q + 5'(1);
                shreg_q  <= {shreg_q[FRAME_BITS-2:0], miso_s};
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (tick && enable_i) state_d = SETUP;
            SETUP:   if (phase_last) state_d = LOW;
            LOW:     if (phase_last) state_d = HIGH;
            HIGH:    if (phase_last) state_d = (bitcnt_q == 5'(FRAME_BITS - 1)) ? HOLD : LOW;
            HOLD:    if (phase_last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode the next state and are registered, so pins change with the state and never glitch.
    always_comb begin
        cs_d   = (state_d == IDLE) || (state_d == DONE);
        sclk_d = (state_d != LOW);
        rdy_d  = (state_d == DONE);
        err_d  = rdy_d && ((shreg_q & ~DATA_MASK) != '0);
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            cs_q   <= 1'b1;
            sclk_q <= 1'b1;
            rdy_q  <= 1'b0;
            err_q  <= 1'b0;
            data_q <= '0;
        end else begin
            cs_q   <= cs_d;
            sclk_q <= sclk_d;
            rdy_q  <= rdy_d;
            err_q  <= err_d;
            if (rdy_d) begin
                data_q <= shreg_q & DATA_MASK;
            end
        end
    end

    assign cs_no       = cs_q;
    assign sclk_o      = sclk_q;
    assign data_o      = data_q;
    assign data_rdy_o  = rdy_q;
    assign frame_err_o = err_q;

endmodule

// File: tb/tb_adc_reader.sv
// Self-checking bench for adc_reader with behavioural ADC models on two configurations.
module tb_adc_reader;

    typedef struct {
        logic [15:0] frame;
        logic [15:0] exp_d;
        logic        exp_e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b0, en2 = 1'b0;
    logic        miso = 1'b0, miso2 = 1'b0;
    logic        cs_n, sclk, rdy, err;
    logic        cs2_n, sclk2, rdy2, err2;
    logic [15:0] data, data2;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          rdy_pulses = 0;
    string       cur_test = "init";

    logic [15:0] adc_word = 16'h0000, cur1 = 16'h0000, cur2 = 16'h0000;
    int          idx1 = 0, falls1 = 0, idx2 = 0, falls2 = 0;

    adc_reader #(.CLK_DIV(4), .SAMPLE_PERIOD(200), .ADC_BITS(12)) dut (
        .clk_i(clk), .reset_ni(rst_n), .enable_i(en), .miso_i(miso),
        .cs_no(cs_n), .sclk_o(sclk), .data_o(data), .data_rdy_o(rdy), .frame_err_o(err)
    );

    adc_reader #(.CLK_DIV(2), .SAMPLE_PERIOD(110), .ADC_BITS(12)) dut2 (
        .clk_i(clk), .reset_ni(rst_n), .enable_i(en2), .miso_i(miso2),
        .cs_no(cs2_n), .sclk_o(sclk2), .data_o(data2), .data_rdy_o(rdy2), .frame_err_o(err2)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    always @(posedge clk) begin
        if (rdy === 1'b1) rdy_pulses <= rdy_pulses + 1;
    end

    // ADC model: frame latched at CS fall, bit k launched just after SCLK falling edge k.
    always @(negedge cs_n) begin
        cur1   = adc_word;
        idx1   = 0;
        falls1 = 0;
        miso   = ~adc_word[15];
    end

    always @(negedge sclk) begin
        if (cs_n === 1'b0) begin
            falls1 = falls1 + 1;
            #1;
            if (idx1 < 16) miso = cur1[15 - idx1];
            idx1 = idx1 + 1;
        end
    end

    // Second ADC model launches each bit one full clk cycle after the SCLK fall.
    always @(negedge cs2_n) begin
        cur2   = 16'h0555;
        idx2   = 0;
        falls2 = 0;
        miso2  = 1'b1;
    end

    always @(negedge sclk2) begin
        if (cs2_n === 1'b0) begin
            falls2 = falls2 + 1;
            @(posedge clk);
            #1;
            if (idx2 < 16) miso2 = cur2[15 - idx2];
            idx2 = idx2 + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s[%s]: actual=0x%0h required=0x%0h", name, cur_test, act, exp);
        end
    endtask

    task automatic wait_cs(input int limit, output int n);
        n = 0;
        while (cs_n !== 1'b0 && n < limit) begin
            @(negedge clk);
            n = n + 1;
        end
        chk("cs_fall_seen", 32'(cs_n), 32'd0);
    endtask

    task automatic finish_frame(input int start, input logic [15:0] exp_d, input logic exp_e);
        int n;
        int p0;
        logic [15:0] held;
        n  = start;
        p0 = rdy_pulses;
        while (rdy !== 1'b1 && n < 200) begin
            @(negedge clk);
            n = n + 1;
        end
        chk("rdy_latency", 32'(n), 32'd136);
        chk("data", 32'(data), 32'(exp_d));
        chk("frame_err", 32'(err), 32'(exp_e));
        chk("sclk_falls", 32'(falls1), 32'd16);
        chk("cs_high_at_done", 32'(cs_n), 32'd1);
        held = data;
        @(negedge clk);
        chk("rdy_width", 32'(rdy), 32'd0);
        chk("err_width", 32'(err), 32'd0);
        chk("rdy_pulse_count", 32'(rdy_pulses - p0), 32'd1);
        chk("data_hold", 32'(data), 32'(held));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[6];
        int   n;
        logic ok;
        logic [15:0] fw;
        int   p0;

        vecs[0] = '{16'hFFFF, 16'h0FFF, 1'b1};
        vecs[1] = '{16'h0000, 16'h0000, 1'b0};
        vecs[2] = '{16'h0555, 16'h0555, 1'b0};
        vecs[3] = '{16'h1000, 16'h0000, 1'b1};
        vecs[4] = '{16'h0800, 16'h0800, 1'b0};
        vecs[5] = '{16'h8001, 16'h0001, 1'b1};

        // Reset state and first-frame timing
        cur_test = "reset";
        en       = 1'b1;
        adc_word = 16'h0ABC;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cs", 32'(cs_n), 32'd1);
        chk("rst_sclk", 32'(sclk), 32'd1);
        chk("rst_data", 32'(data), 32'd0);
        chk("rst_rdy", 32'(rdy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        n  = 0;
        ok = 1'b1;
        while (cs_n !== 1'b0 && n < 400) begin
            @(negedge clk);
            n = n + 1;
            if (cs_n === 1'b1 && (sclk !== 1'b1 || data !== 16'h0000)) ok = 1'b0;
        end
        chk("idle_outputs", 32'(ok), 32'd1);
        chk("first_cs_fall", 32'(n), 32'd200);
        cur_test = "0x0ABC";
        finish_frame(0, 16'h0ABC, 1'b0);

        for (int i = 0; i < 6; i++) begin
            cur_test = $sformatf("vec%0d", i);
            adc_word = vecs[i].frame;
            wait_cs(300, n);
            chk("tick_align", 32'(cyc % 200), 32'd0);
            finish_frame(0, vecs[i].exp_d, vecs[i].exp_e);
        end

        for (int i = 0; i < 6; i++) begin
            cur_test = $sformatf("rand%0d", i);
            fw = 16'($urandom);
            if ($urandom_range(0, 3) != 0) fw = fw % 16'd4096;
            adc_word = fw;
            wait_cs(300, n);
            finish_frame(0, 16'(int'(fw) % 4096), (int'(fw) >= 4096));
        end

        // enable_i dropped mid-frame
        cur_test = "enable_drop";
        adc_word = 16'h0321;
        wait_cs(300, n);
        repeat (50) @(negedge clk);
        en = 1'b0;
        finish_frame(50, 16'h0321, 1'b0);
        p0 = rdy_pulses;
        ok = 1'b1;
        repeat (600) begin
            @(negedge clk);
            if (cs_n !== 1'b1 || sclk !== 1'b1) ok = 1'b0;
        end
        chk("disabled_quiet", 32'(ok), 32'd1);
        chk("disabled_no_rdy", 32'(rdy_pulses - p0), 32'd0);
        en = 1'b1;
        adc_word = 16'h0456;
        wait_cs(250, n);
        chk("resume_tick_align", 32'(cyc % 200), 32'd0);
        finish_frame(0, 16'h0456, 1'b0);

        // Asynchronous reset mid-frame
        cur_test = "reset_mid";
        adc_word = 16'h0789;
        wait_cs(300, n);
        repeat (70) @(negedge clk);
        p0 = rdy_pulses;
        #2 rst_n = 1'b0;
        #1;
        chk("async_cs", 32'(cs_n), 32'd1);
        chk("async_sclk", 32'(sclk), 32'd1);
        chk("async_data", 32'(data), 32'd0);
        chk("async_rdy", 32'(rdy), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_cs(400, n);
        chk("restart_cs_fall", 32'(n), 32'd200);
        chk("no_rdy_after_abort", 32'(rdy_pulses - p0), 32'd0);
        finish_frame(0, 16'h0789, 1'b0);
        en = 1'b0;

        // CLK_DIV=2 with late MISO transitions
        cur_test = "div2";
        en2 = 1'b1;
        n = 0;
        while (cs2_n !== 1'b0 && n < 250) begin
            @(negedge clk);
            n = n + 1;
        end
        chk("div2_cs_fall_seen", 32'(cs2_n), 32'd0);
        n = 0;
        while (rdy2 !== 1'b1 && n < 120) begin
            @(negedge clk);
            n = n + 1;
        end
        en2 = 1'b0;
        chk("div2_rdy_latency", 32'(n), 32'd68);
        chk("div2_data", 32'(data2), 32'h0555);
        chk("div2_err", 32'(err2), 32'd0);
        chk("div2_sclk_falls", 32'(falls2), 32'd16);
        @(negedge clk);
        chk("div2_rdy_width", 32'(rdy2), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adc_reader.md
# adc_reader

Periodic SPI read-out master for a 12-bit serial ADC (AD7476-style: CPOL=1, data launched on SCLK falling edge, 4 leading zeros then 12 data bits MSB first). Runs a free-running sample timer, clocks one 16-bit frame per tick, and presents the right-justified sample on a 16-bit word with a one-cycle ready pulse. Sits directly upstream of `shiftout`: `data_o` drives its `data_i`, `data_rdy_o` drives its `data_rdy_i`.

## Interface
- `CLK_DIV`, 4: SCLK half-period in `clk_i` cycles; legal range 2..255.
- `SAMPLE_PERIOD`, 1200: `clk_i` cycles between frame starts; must be ≥ FRAME_LEN + 40, where FRAME_LEN = 34·CLK_DIV. Smaller values are illegal and need not be supported.
- `ADC_BITS`, 12: valid data bits at the end of the frame; legal range 1..16.
- `clk_i`  in  1  system clock; all logic is on its rising edge.
- `reset_ni`  in  1  asynchronous, active-low reset.
- `enable_i`  in  1  high: timer ticks start frames; low: no new frames.
- `miso_i`  in  1  ADC serial data; asynchronous to `clk_i`.
- `cs_no`  out  1  ADC chip select, active low.
- `sclk_o`  out  1  SPI clock, idle high.
- `data_o`  out  16  last sample, right-justified; bits above ADC_BITS are 0.
- `data_rdy_o`  out  1  one-cycle pulse when `data_o` updates.
- `frame_err_o`  out  1  one-cycle pulse, coincident with `data_rdy_o`, when any leading (non-data) bit read back as 1.

## Operation
- Reset values: `cs_no`=1, `sclk_o`=1, `data_o`=0, `data_rdy_o`=0, `frame_err_o`=0, timer=0, state IDLE.
- `miso_i` passes through a 2-FF synchronizer. Only the synchronized value is sampled.
- Timer: counts 0..SAMPLE_PERIOD-1 and wraps. It runs regardless of `enable_i` or state. A tick is timer==SAMPLE_PERIOD-1.
- States:
  - IDLE: `cs_no`=1, `sclk_o`=1. On tick with `enable_i`=1, go to SETUP. A tick with `enable_i`=0 is ignored.
  - SETUP: `cs_no`=0 for CLK_DIV cycles, then go to LOW.
  - LOW: `sclk_o`=0 for CLK_DIV cycles, then go to HIGH.
  - HIGH: `sclk_o`=1 for CLK_DIV cycles. In the last cycle, shift the synchronized MISO into a 16-bit register (MSB first) and increment the bit count. After the 16th bit go to HOLD; otherwise go to LOW.
  - HOLD: `cs_no`=0, `sclk_o`=1 for CLK_DIV cycles, then go to DONE.
  - DONE (1 cycle):
    - `cs_no`=1.
    - `data_o` ← shreg masked to the low ADC_BITS bits.
    - `data_rdy_o`=1.
    - `frame_err_o`=1 if any of shreg[15:ADC_BITS] is 1.
    - Go to IDLE.
- `data_o` holds its value between DONE cycles; the downstream stage may read it at any time.
- If `enable_i` falls mid-frame, the current frame completes normally, including its ready pulse.
- Ticks that occur outside IDLE are ignored; no queuing.
- Reset asserted mid-frame: all outputs return to reset values immediately (async), and the partial frame is discarded.

## Timing
- Let cycle 0 be the first SETUP cycle, i.e. the cycle after the tick.
- `cs_no` falls at cycle 0.
- SCLK falling edge k (k=0..15) occurs at cycle CLK_DIV·(1+2k).
- Bit k is sampled at cycle CLK_DIV·(3+2k)−1. This gives ≥ 2·CLK_DIV−1 cycles after the launching falling edge, which covers the 2-cycle synchronizer.
- HOLD starts at cycle 33·CLK_DIV. DONE is at cycle 34·CLK_DIV, where `cs_no` rises and `data_rdy_o`=1.
- With CLK_DIV=4: frame 136 cycles, `data_rdy_o` at cycle 136, 16 SCLK periods of 8 cycles.
- `data_rdy_o` is exactly one cycle wide, and at least SAMPLE_PERIOD cycles separate pulses, so the downstream rising-edge detector sees each pulse once.

## Structure
- Package `adc_reader_pkg`: state enum (IDLE, SETUP, LOW, HIGH, HOLD, DONE), FRAME_BITS=16, and a FRAME_LEN function of CLK_DIV.
- Sub-module `sync_2ff` for `miso_i` (generic 1-bit, reusable elsewhere in the design).
- The phase counter (CLK_DIV), bit counter (0..16), sample timer and FSM stay in `adc_reader`.

## Test plan
- Reset with `enable_i`=1, `SAMPLE_PERIOD`=200, CLK_DIV=4 -> `cs_no`=1, `sclk_o`=1, `data_o`=0 until first tick; first `cs_no` fall at cycle 200, `data_rdy_o` at 136 cycles after that.
- ADC model returns 0x0ABC framed as 0000_1010_1011_1100 on SCLK falling edges -> `data_o`=0x0ABC, one `data_rdy_o` pulse, `frame_err_o`=0; exactly 16 SCLK falling edges while `cs_no`=0.
- ADC model drives leading bits 1 with data 0xFFF (frame 0xFFFF) -> `data_o`=0x0FFF, `frame_err_o`=1 on the same cycle as `data_rdy_o`.
- Drop `enable_i` at cycle 50 of a frame -> frame completes with a correct sample; no further `cs_no` activity for 3 timer periods; re-enable -> frames resume on the next tick.
- Assert `reset_ni` at cycle 70 of a frame -> `cs_no`=1, `sclk_o`=1, `data_o`=0 asynchronously, no `data_rdy_o`; after release, the next frame starts SAMPLE_PERIOD cycles later and reads correctly.
- CLK_DIV=2 with `miso_i` transitions delayed 1 cycle after each SCLK falling edge -> all 16 bits captured correctly (0x0555 pattern), `data_rdy_o` at cycle 68.
